// File: rtl/vga_timing_pkg.sv
// ============================================================================
// vga_timing_pkg : segment encoding, register map and 640x480 defaults
// Revision: 1.0
// ============================================================================
`default_nettype none

package vga_timing_pkg;

    typedef enum logic [1:0] {
        SEG_SYNC   = 2'd0,
        SEG_BACK   = 2'd1,
        SEG_ACTIVE = 2'd2,
        SEG_FRONT  = 2'd3
    } seg_e;

    localparam logic [2:0] ADDR_H_ACTIVE = 3'd0;
    localparam logic [2:0] ADDR_H_FP     = 3'd1;
    localparam logic [2:0] ADDR_H_SYNC   = 3'd2;
    localparam logic [2:0] ADDR_H_BP     = 3'd3;
    localparam logic [2:0] ADDR_V_ACTIVE = 3'd4;
    localparam logic [2:0] ADDR_V_FP     = 3'd5;
    localparam logic [2:0] ADDR_V_SYNC   = 3'd6;
    localparam logic [2:0] ADDR_V_BP     = 3'd7;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    function automatic int default_value(input logic [2:0] addr);
        case (addr)
            ADDR_H_ACTIVE: return DEF_H_ACTIVE;
            ADDR_H_FP:     return DEF_H_FP;
            ADDR_H_SYNC:   return DEF_H_SYNC;
            ADDR_H_BP:     return DEF_H_BP;
            ADDR_V_ACTIVE: return DEF_V_ACTIVE;
            ADDR_V_FP:     return DEF_V_FP;
            ADDR_V_SYNC:   return DEF_V_SYNC;
            default:       return DEF_V_BP;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/vga_seg_counter.sv
// ============================================================================
// vga_seg_counter : segment state + count, advancing one unit per step
// Revision: 1.0
// ============================================================================
`default_nettype none

module vga_seg_counter
    import vga_timing_pkg::*;
#(
    parameter int CNT_BITS = 12
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          step,
    input  logic [3:0][CNT_BITS-1:0]      seg_len,
    output seg_e                          seg,
    output logic [CNT_BITS-1:0]           cnt,
    output logic                          seg_last
);

    localparam logic [CNT_BITS-1:0] C_ONE = CNT_BITS'(1);

    seg_e                seg_q, seg_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;

    always_comb begin
        seg_d    = seg_q;
        cnt_d    = cnt_q;
        seg_last = (cnt_q == (seg_len[seg_q] - C_ONE));
        if (step) begin
            if (seg_last) begin
                cnt_d = '0;
                case (seg_q)
                    SEG_SYNC:   seg_d = SEG_BACK;
                    SEG_BACK:   seg_d = SEG_ACTIVE;
                    SEG_ACTIVE: seg_d = SEG_FRONT;
                    default:    seg_d = SEG_SYNC;
                endcase
            end else begin
                cnt_d = cnt_q + C_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q <= SEG_SYNC;
            cnt_q <= '0;
        end else begin
            seg_q <= seg_d;
            cnt_q <= cnt_d;
        end
    end

    assign seg = seg_q;
    assign cnt = cnt_q;

endmodule

`default_nettype wire

// File: rtl/vga_timing_ctrl.sv
// ============================================================================
// vga_timing_ctrl : programmable VGA sync / data-enable generator
// Revision: 1.0
// ============================================================================
`default_nettype none

module vga_timing_ctrl
    import vga_timing_pkg::*;
#(
    parameter int CNT_BITS = 12
) (
    input  logic                vga_clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                cfg_wr,
    input  logic [2:0]          cfg_addr,
    input  logic [CNT_BITS-1:0] cfg_wdata,
    input  logic                hs_pol,
    input  logic                vs_pol,
    output logic                vga_hs,
    output logic                vga_vs,
    output logic                vga_de,
    output logic [CNT_BITS-1:0] vga_x,
    output logic [CNT_BITS-1:0] vga_y,
    output logic                pix_req,
    output logic                frame_start
);

    localparam logic [CNT_BITS-1:0] C_ONE = CNT_BITS'(1);

    logic [7:0][CNT_BITS-1:0] stage_q, stage_d, work_q, work_d, eff;
    logic                     work_hs_pol_q, work_hs_pol_d, work_vs_pol_q, work_vs_pol_d;
    logic                     eff_hs_pol, eff_vs_pol;
    logic                     in_frame_q, in_frame_d;
    logic                     go, new_frame, h_wrap, frame_end, h_active_nxt;
    logic [3:0][CNT_BITS-1:0] h_len, v_len;

    seg_e                h_seg, v_seg;
    logic [CNT_BITS-1:0] h_cnt, v_cnt;
    logic                h_last, v_last;

    logic                hs_q, hs_d, vs_q, vs_d, de_q, de_d;
    logic                pix_req_q, pix_req_d, frame_start_q, frame_start_d;
    logic [CNT_BITS-1:0] x_q, x_d, y_q, y_d;

    always_comb begin
        go        = in_frame_q || enable;
        new_frame = !in_frame_q && enable;

        // The first cycle of a frame already runs on the staged values.
        eff        = new_frame ? stage_q : work_q;
        eff_hs_pol = new_frame ? hs_pol  : work_hs_pol_q;
        eff_vs_pol = new_frame ? vs_pol  : work_vs_pol_q;

        h_len[SEG_SYNC]   = eff[ADDR_H_SYNC];
        h_len[SEG_BACK]   = eff[ADDR_H_BP];
        h_len[SEG_ACTIVE] = eff[ADDR_H_ACTIVE];
        h_len[SEG_FRONT]  = eff[ADDR_H_FP];
        v_len[SEG_SYNC]   = eff[ADDR_V_SYNC];
        v_len[SEG_BACK]   = eff[ADDR_V_BP];
        v_len[SEG_ACTIVE] = eff[ADDR_V_ACTIVE];
        v_len[SEG_FRONT]  = eff[ADDR_V_FP];

        h_wrap       = (h_seg == SEG_FRONT) && h_last;
        frame_end    = h_wrap && (v_seg == SEG_FRONT) && v_last;
        in_frame_d   = go && !frame_end;
        h_active_nxt = ((h_seg == SEG_ACTIVE) && !h_last) || ((h_seg == SEG_BACK) && h_last);

        stage_d = stage_q;
        if (cfg_wr) begin
            stage_d[cfg_addr] = (cfg_wdata == '0) ? C_ONE : cfg_wdata;
        end
        work_d        = new_frame ? stage_q : work_q;
        work_hs_pol_d = eff_hs_pol;
        work_vs_pol_d = eff_vs_pol;

        hs_d          = (go && (h_seg == SEG_SYNC)) ? eff_hs_pol : ~eff_hs_pol;
        vs_d          = (go && (v_seg == SEG_SYNC)) ? eff_vs_pol : ~eff_vs_pol;
        de_d          = go && (h_seg == SEG_ACTIVE) && (v_seg == SEG_ACTIVE);
        x_d           = de_d ? h_cnt : '0;
        y_d           = de_d ? v_cnt : '0;
        // Vertical segment cannot change unless the line wraps, which never lands in ACTIVE.
        pix_req_d     = go && (v_seg == SEG_ACTIVE) && h_active_nxt;
        frame_start_d = new_frame;
    end

    vga_seg_counter #(.CNT_BITS(CNT_BITS)) u_h_cnt (
        .clk      (vga_clk),
        .rst      (rst),
        .step     (go),
        .seg_len  (h_len),
        .seg      (h_seg),
        .cnt      (h_cnt),
        .seg_last (h_last)
    );

    vga_seg_counter #(.CNT_BITS(CNT_BITS)) u_v_cnt (
        .clk      (vga_clk),
        .rst      (rst),
        .step     (go && h_wrap),
        .seg_len  (v_len),
        .seg      (v_seg),
        .cnt      (v_cnt),
        .seg_last (v_last)
    );

    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                stage_q[i] <= CNT_BITS'(default_value(3'(i)));
                work_q[i]  <= CNT_BITS'(default_value(3'(i)));
            end
            work_hs_pol_q <= 1'b0;
            work_vs_pol_q <= 1'b0;
            in_frame_q    <= 1'b0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            de_q          <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            pix_req_q     <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            stage_q       <= stage_d;
            work_q        <= work_d;
            work_hs_pol_q <= work_hs_pol_d;
            work_vs_pol_q <= work_vs_pol_d;
            in_frame_q    <= in_frame_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            de_q          <= de_d;
            x_q           <= x_d;
            y_q           <= y_d;
            pix_req_q     <= pix_req_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vga_de      = de_q;
    assign vga_x       = x_q;
    assign vga_y       = y_q;
    assign pix_req     = pix_req_q;
    assign frame_start = frame_start_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_ctrl.sv
// ============================================================================
// tb_vga_timing_ctrl : directed frames with a per-cycle expected-output queue
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_vga_timing_ctrl;

    localparam int W = 12;

    logic         vga_clk = 1'b0;
    logic         rst     = 1'b1;
    logic         enable  = 1'b0;
    logic         cfg_wr  = 1'b0;
    logic [2:0]   cfg_addr  = '0;
    logic [W-1:0] cfg_wdata = '0;
    logic         hs_pol = 1'b0;
    logic         vs_pol = 1'b0;
    logic         vga_hs, vga_vs, vga_de, pix_req, frame_start;
    logic [W-1:0] vga_x, vga_y;

    vga_timing_ctrl #(.CNT_BITS(W)) dut (
        .vga_clk     (vga_clk),
        .rst         (rst),
        .enable      (enable),
        .cfg_wr      (cfg_wr),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .hs_pol      (hs_pol),
        .vs_pol      (vs_pol),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vga_de      (vga_de),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .pix_req     (pix_req),
        .frame_start (frame_start)
    );

    always #5 vga_clk = ~vga_clk;

    typedef struct packed {
        logic         hs;
        logic         vs;
        logic         de;
        logic         pr;
        logic         fs;
        logic [W-1:0] x;
        logic [W-1:0] y;
    } vec_t;

    typedef struct {
        int   tag;
        vec_t v;
    } ent_t;

    // len[] indexed by register address: H_ACTIVE,H_FP,H_SYNC,H_BP,V_ACTIVE,V_FP,V_SYNC,V_BP
    typedef struct {
        int len[8];
        bit hp;
        bit vp;
    } cfg_t;

    ent_t exp_q[$];
    cfg_t stage, work, defaults;
    int   checks   = 0;
    int   failures = 0;
    int   frame_id = 0;

    function automatic int htot(cfg_t w);
        return w.len[0] + w.len[1] + w.len[2] + w.len[3];
    endfunction

    function automatic int vtot(cfg_t w);
        return w.len[4] + w.len[5] + w.len[6] + w.len[7];
    endfunction

    function automatic bit is_de(cfg_t w, int c);
        int px;
        int ln;
        px = c % htot(w);
        ln = c / htot(w);
        return (px >= w.len[2] + w.len[3]) && (px < w.len[2] + w.len[3] + w.len[0]) &&
               (ln >= w.len[6] + w.len[7]) && (ln < w.len[6] + w.len[7] + w.len[4]);
    endfunction

    function automatic vec_t model(cfg_t w, int c);
        vec_t v;
        int   px;
        int   ln;
        px   = c % htot(w);
        ln   = c / htot(w);
        v.hs = (px < w.len[2]) ? w.hp : !w.hp;
        v.vs = (ln < w.len[6]) ? w.vp : !w.vp;
        v.de = is_de(w, c);
        v.x  = v.de ? W'(px - w.len[2] - w.len[3]) : '0;
        v.y  = v.de ? W'(ln - w.len[6] - w.len[7]) : '0;
        v.pr = (c + 1 < htot(w) * vtot(w)) && is_de(w, c + 1);
        v.fs = (c == 0);
        return v;
    endfunction

    function automatic vec_t idle_vec();
        vec_t v;
        v    = '0;
        v.hs = !work.hp;
        v.vs = !work.vp;
        return v;
    endfunction

    function automatic vec_t reset_vec();
        vec_t v;
        v    = '0;
        v.hs = 1'b1;
        v.vs = 1'b1;
        return v;
    endfunction

    function automatic vec_t cur_vec();
        return {vga_hs, vga_vs, vga_de, pix_req, frame_start, vga_x, vga_y};
    endfunction

    task automatic check_vec(int tag, vec_t got, vec_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL outputs tag=%0d got hs=%b vs=%b de=%b pr=%b fs=%b x=%0d y=%0d required hs=%b vs=%b de=%b pr=%b fs=%b x=%0d y=%0d",
                     tag, got.hs, got.vs, got.de, got.pr, got.fs, got.x, got.y,
                     exp.hs, exp.vs, exp.de, exp.pr, exp.fs, exp.x, exp.y);
        end
    endtask

    // Monitor: every expected entry describes the DUT outputs of one cycle.
    always @(negedge vga_clk) begin
        if (exp_q.size() != 0) begin
            ent_t e;
            e = exp_q.pop_front();
            check_vec(e.tag, cur_vec(), e.v);
        end
    end

    task automatic tick_push(vec_t v, int tag);
        ent_t e;
        @(posedge vga_clk);
        #1;
        e.tag = tag;
        e.v   = v;
        exp_q.push_back(e);
    endtask

    task automatic scramble();
        cfg_wr    = 1'b0;
        cfg_addr  = 3'($urandom);
        cfg_wdata = W'($urandom);
    endtask

    task automatic stage_write(logic [2:0] a, int d);
        stage.len[a] = (d == 0) ? 1 : d;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            tick_push(idle_vec(), -1);
            scramble();
        end
    endtask

    task automatic write_reg(logic [2:0] a, int d);
        cfg_wr    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = W'(d);
        stage_write(a, d);
        tick_push(idle_vec(), -2);
        scramble();
    endtask

    // One frame (or its first stop_at+1 cycles); enable must already be high.
    task automatic run_frame(int wr_at, logic [2:0] wa, int wd, int pol_at, bit nhp, bit nvp,
                             int drop_at, int stop_at);
        int limit;
        frame_id++;
        work    = stage;
        work.hp = hs_pol;
        work.vp = vs_pol;
        limit   = (stop_at >= 0) ? stop_at + 1 : htot(work) * vtot(work);
        for (int c = 0; c < limit; c++) begin
            tick_push(model(work, c), frame_id * 100000 + c);
            if (c == wr_at) begin
                cfg_wr    = 1'b1;
                cfg_addr  = wa;
                cfg_wdata = W'(wd);
                stage_write(wa, wd);
            end else begin
                scramble();
            end
            if (c == pol_at) begin
                hs_pol = nhp;
                vs_pol = nvp;
            end
            if (c == drop_at) enable = 1'b0;
        end
    endtask

    task automatic async_reset();
        #6;
        rst = 1'b1;
        #1;
        check_vec(-3, cur_vec(), reset_vec());
        stage  = defaults;
        work   = defaults;
        enable = 1'b0;
        tick_push(reset_vec(), -4);
        tick_push(reset_vec(), -4);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired pending=%0d required 0", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        defaults.len = '{640, 16, 96, 48, 480, 10, 2, 33};
        defaults.hp  = 1'b0;
        defaults.vp  = 1'b0;
        stage        = defaults;
        work         = defaults;
        scramble();

        for (int i = 0; i < 3; i++) tick_push(reset_vec(), -4);
        rst = 1'b0;
        idle(3);

        // Default 640x480: first two-plus lines (line period, hsync width, 2 vsync lines).
        enable = 1'b1;
        run_frame(-1, 3'd0, 0, -1, 1'b0, 1'b0, -1, 1700);
        async_reset();
        idle(3);

        // Tiny mode: H 4/1/2/1, V 2/1/1/1.
        write_reg(3'd0, 4);
        write_reg(3'd1, 1);
        write_reg(3'd2, 2);
        write_reg(3'd3, 1);
        write_reg(3'd4, 2);
        write_reg(3'd5, 1);
        write_reg(3'd6, 1);
        write_reg(3'd7, 1);
        enable = 1'b1;
        run_frame(-1, 3'd0, 0, -1, 1'b0, 1'b0, -1, -1);
        run_frame(-1, 3'd0, 0, -1, 1'b0, 1'b0, -1, -1);
        // Mid-frame H_ACTIVE and polarity change; both wait for the next frame.
        run_frame(10, 3'd0, 3, 12, 1'b1, 1'b1, -1, -1);
        // Write during the frame_start cycle lands one frame later.
        run_frame(0, 3'd1, 2, -1, 1'b1, 1'b1, -1, -1);
        // Zero write clamps to 1; enable falls mid-frame.
        run_frame(3, 3'd2, 0, -1, 1'b1, 1'b1, 5, -1);
        idle(4);
        enable = 1'b1;
        run_frame(-1, 3'd0, 0, -1, 1'b1, 1'b1, -1, -1);
        // Abort inside an active pixel (line 2, pixel 2).
        run_frame(-1, 3'd0, 0, -1, 1'b1, 1'b1, -1, 16);
        async_reset();
        enable = 1'b1;
        run_frame(-1, 3'd0, 0, -1, 1'b1, 1'b1, -1, 20);
        enable = 1'b0;

        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge vga_clk);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vga_timing_ctrl.md
VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

Interface
REQ-001 SHALL have parameter CNT_BITS, default 12, width of every timing value, counter and coordinate output.
REQ-002 SHALL have port vga_clk, input, 1, pixel clock; the only clock.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-004 SHALL have port enable, input, 1, run request for the timing generator.
REQ-005 SHALL have port cfg_wr, input, 1, single-cycle write strobe for a timing register.
REQ-006 SHALL have port cfg_addr, input, 3, register select: 0 H_ACTIVE, 1 H_FP, 2 H_SYNC, 3 H_BP, 4 V_ACTIVE, 5 V_FP, 6 V_SYNC, 7 V_BP.
REQ-007 SHALL have port cfg_wdata, input, CNT_BITS, register write value.
REQ-008 SHALL have ports hs_pol and vs_pol, input, 1 each, sync polarity (1 means active-high pulse).
REQ-009 SHALL have ports vga_hs, vga_vs and vga_de, output, 1 each, registered sync and data-enable for the DDR output stage.
REQ-010 SHALL have ports vga_x and vga_y, output, CNT_BITS each, active pixel coordinates.
REQ-011 SHALL have port pix_req, output, 1, pixel fetch request leading vga_de by one cycle.
REQ-012 SHALL have port frame_start, output, 1, one-cycle pulse on the first cycle of every frame.

Function
REQ-013 SHALL order horizontal segments SYNC, BACK, ACTIVE, FRONT per line and vertical segments SYNC, BACK, ACTIVE, FRONT per frame; each segment lasts exactly its register value in clocks (H) or lines (V).
REQ-014 SHALL clamp a written value of 0 to 1 at write time.
REQ-015 SHALL hold written values in a staging set and copy them, plus hs_pol and vs_pol, to the working set only at a frame boundary (the cycle frame_start is asserted); a write in that same cycle applies one frame later.
REQ-016 SHALL drive vga_hs = hs_pol during H SYNC, else ~hs_pol; vga_vs = vs_pol during V SYNC (whole lines, line-aligned at H SYNC start), else ~vs_pol.
REQ-017 SHALL assert vga_de only while both H and V are in ACTIVE; vga_x counts 0..H_ACTIVE-1 and vga_y counts 0..V_ACTIVE-1; both hold 0 outside active.
REQ-018 SHALL assert pix_req exactly one cycle before every vga_de-high cycle, including the cycle before the first pixel of each active line; pix_req count per frame equals H_ACTIVE*V_ACTIVE.
REQ-019 SHALL register all outputs, with no combinational path from any input to any output.
REQ-020 SHALL start frame 0 at H SYNC and V SYNC on the first cycle after enable is sampled high from idle, with frame_start high on that cycle.
REQ-021 SHALL finish the current frame when enable falls, then idle with sync outputs inactive, vga_de and pix_req low, and coordinates 0; if enable is high again at that frame end, no idle cycle is inserted.
REQ-022 SHALL ignore cfg_addr and cfg_wdata when cfg_wr is low.

Reset
REQ-023 SHALL on rst load both the staging and working sets to 640x480 values (H 640/16/96/48, V 480/10/2/33) with polarity active-low, and enter idle.
REQ-024 SHALL on rst drive vga_hs=1, vga_vs=1, vga_de=0, pix_req=0, frame_start=0, vga_x=0 and vga_y=0.
REQ-025 SHALL on rst mid-frame abort the frame immediately and restart at REQ-020 once rst deasserts and enable is high.

Structure
REQ-026 SHALL take the segment state encoding, register address map and 640x480 default constants from the shared package vga_timing_pkg.
REQ-027 SHALL instantiate sub-module vga_seg_counter twice, for H and V; it holds the segment state and count and advances on a step input.

Verification
REQ-028 SHALL cover: reset then enable -> line period 800 clocks, frame 525 lines, hs low 96 clocks, vs low for 2 lines, 307200 de cycles per frame.
REQ-029 SHALL cover: write H 4/1/2/1 and V 2/1/1/1, then enable -> 8-clock lines, 5-line frames, 8 de cycles per frame, pix_req one cycle ahead of each.
REQ-030 SHALL cover: write H_ACTIVE=320 mid-frame -> current frame keeps 640, next frame_start onward shows 320.
REQ-031 SHALL cover: hs_pol=1 with vs_pol=1 changed mid-frame -> polarity flips only at the next frame_start.
REQ-032 SHALL cover: enable falls mid-frame -> frame completes, then outputs idle; writing cfg_wdata=0 -> value reads as 1-length segment.
REQ-033 SHALL cover: rst asserted mid-active line -> outputs at reset values in the same cycle, clean frame_start after release.
